// File: rtl/rot_pkg.sv
// Shared types and elaboration helpers for the
// pipelined rotate/shift unit.
package rot_pkg;

   typedef enum logic [1:0] {
      ROT_ROR = 2'b00,
      ROT_ROL = 2'b01,
      ROT_SHR = 2'b10,
      ROT_SRA = 2'b11
   } rot_op_t;

   function automatic int popcount_mask(
      input logic [31:0] mask,
      input int          n
   );
      int c;
      c = 0;
      for (int i = 0; i < n; i++) begin
         if (mask[i]) c++;
      end
      return c;
   endfunction

   // Packed width of one beat: data, amt, op, sign, tag
   function automatic int beat_width(
      input int w,
      input int shw,
      input int tagw
   );
      return w + shw + $bits(rot_op_t) + 1 + tagw;
   endfunction

endpackage

// File: rtl/rot_stage.sv
// One log-shifter layer (shift by 2^K) with an
// optional elastic output register.
module rot_stage
   import rot_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH),
   parameter int TAGW  = 4,
   parameter int K     = 0,
   parameter bit REG   = 1'b1,
   localparam int PW   = beat_width(WIDTH, SHW, TAGW)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [PW-1:0] beat_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [PW-1:0] beat_o
);

   localparam int S = 1 << K;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SHW-1:0]   amt;
      rot_op_t          op;
      logic             sign;
      logic [TAGW-1:0]  tag;
   } beat_t;

   beat_t cur;
   beat_t shf;
   logic  fill;

   assign cur = beat_i;

   always_comb begin
      shf  = cur;
      fill = (cur.op == ROT_SRA) ? cur.sign : 1'b0;
      if (cur.amt[K]) begin
         if (cur.op == ROT_ROR || cur.op == ROT_ROL) begin
            shf.data = {cur.data[S-1:0], cur.data[WIDTH-1:S]};
         end else begin
            shf.data = {{S{fill}}, cur.data[WIDTH-1:S]};
         end
      end
   end

   if (REG) begin : g_reg
      beat_t valid_unused_pad;
      beat_t beat_q;
      beat_t beat_d;
      logic  valid_q;
      logic  valid_d;

      assign valid_unused_pad = '0;
      assign ready_o = !valid_q || ready_i;

      // Load only when the slot frees up, so a stalled
      // beat stays put on the output.
      always_comb begin
         valid_d = valid_q;
         beat_d  = beat_q;
         if (ready_o) begin
            valid_d = valid_i;
            if (valid_i) beat_d = shf;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
         end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
         end
      end

      assign valid_o = valid_q;
      assign beat_o  = beat_q;
   end else begin : g_comb
      logic unused_clk;

      assign unused_clk = clk ^ rst;
      assign ready_o    = ready_i;
      assign valid_o    = valid_i;
      assign beat_o     = shf;
   end

endmodule

// File: rtl/rotshift_pipe.sv
// Pipelined barrel rotator/shifter: ROR, ROL, SHR, SRA
// with per-stage valid/ready and selectable registers.
module rotshift_pipe
   import rot_pkg::*;
#(
   parameter int             WIDTH    = 32,
   parameter int             SHW      = $clog2(WIDTH),
   parameter int             TAGW     = 4,
   parameter logic [SHW-1:0] REG_MASK = 'b10010
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [1:0]       in_op,
   input  logic [TAGW-1:0]  in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAGW-1:0]  out_tag
);

   localparam int PW  = beat_width(WIDTH, SHW, TAGW);
   localparam int LAT = popcount_mask(32'(REG_MASK), SHW);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SHW-1:0]   amt;
      rot_op_t          op;
      logic             sign;
      logic [TAGW-1:0]  tag;
   } beat_t;

   beat_t head;
   beat_t tail;
   logic  unused_tail;

   // ROL by n is ROR by (WIDTH - n) mod WIDTH; the
   // modulo falls out of the SHW-bit negate.
   always_comb begin
      head.data = in_data;
      head.op   = rot_op_t'(in_op);
      head.amt  = in_amt;
      if (rot_op_t'(in_op) == ROT_ROL) begin
         head.amt = '0 - in_amt;
      end
      head.sign = in_data[WIDTH-1];
      head.tag  = in_tag;
   end

   for (genvar k = 0; k < SHW; k++) begin : g_st
      logic          v_in;
      logic          r_in;
      logic          v_out;
      logic          r_out;
      logic [PW-1:0] b_in;
      logic [PW-1:0] b_out;

      if (k == 0) begin : g_head
         assign v_in = in_valid;
         assign b_in = head;
      end else begin : g_link
         assign v_in = g_st[k-1].v_out;
         assign b_in = g_st[k-1].b_out;
      end

      if (k == SHW - 1) begin : g_tail
         assign r_out = out_ready;
      end else begin : g_next
         assign r_out = g_st[k+1].r_in;
      end

      rot_stage #(
         .WIDTH (WIDTH),
         .SHW   (SHW),
         .TAGW  (TAGW),
         .K     (k),
         .REG   (REG_MASK[k])
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .valid_i (v_in),
         .ready_o (r_in),
         .beat_i  (b_in),
         .valid_o (v_out),
         .ready_i (r_out),
         .beat_o  (b_out)
      );
   end

   if (LAT == 0) begin : g_wire
      assign in_ready = out_ready;
   end else begin : g_pipe
      assign in_ready = g_st[0].r_in;
   end

   assign tail        = g_st[SHW-1].b_out;
   assign out_valid   = g_st[SHW-1].v_out;
   assign out_data    = tail.data;
   assign out_tag     = tail.tag;
   assign unused_tail = ^{tail.amt, tail.op, tail.sign};

endmodule

// File: tb/tb_rotshift_pipe.sv
// Directed bench for rotshift_pipe: pipelined default
// build plus a fully combinational REG_MASK=0 build.
module tb_rotshift_pipe;

   localparam logic [1:0] OP_ROR = 2'b00;
   localparam logic [1:0] OP_ROL = 2'b01;
   localparam logic [1:0] OP_SHR = 2'b10;
   localparam logic [1:0] OP_SRA = 2'b11;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_amt;
   logic [1:0]  in_op;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_tag;

   logic        c_in_valid;
   logic        c_in_ready;
   logic [31:0] c_in_data;
   logic [4:0]  c_in_amt;
   logic [1:0]  c_in_op;
   logic [3:0]  c_in_tag;
   logic        c_out_valid;
   logic        c_out_ready;
   logic [31:0] c_out_data;
   logic [3:0]  c_out_tag;

   int checks;
   int errors;

   rotshift_pipe #(
      .WIDTH    (32),
      .TAGW     (4),
      .REG_MASK (5'b10010)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   rotshift_pipe #(
      .WIDTH    (32),
      .TAGW     (4),
      .REG_MASK (5'b00000)
   ) u_comb (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (c_in_valid),
      .in_ready  (c_in_ready),
      .in_data   (c_in_data),
      .in_amt    (c_in_amt),
      .in_op     (c_in_op),
      .in_tag    (c_in_tag),
      .out_valid (c_out_valid),
      .out_ready (c_out_ready),
      .out_data  (c_out_data),
      .out_tag   (c_out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(
      input logic [1:0]  op,
      input logic [4:0]  amt,
      input logic [31:0] d
   );
      logic [63:0] dd;
      logic [63:0] r;
      dd = {d, d};
      case (op)
         OP_ROR:  begin r = dd >> amt; return r[31:0]; end
         OP_ROL:  begin r = dd << amt; return r[63:32]; end
         OP_SHR:  return d >> amt;
         default: return 32'($signed(d) >>> amt);
      endcase
   endfunction

   task automatic chk(
      input string       name,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run1(
      input string       name,
      input logic [1:0]  op,
      input logic [4:0]  amt,
      input logic [31:0] d,
      input logic [3:0]  tg,
      input logic [31:0] exp
   );
      in_valid = 1'b1;
      in_op    = op;
      in_amt   = amt;
      in_data  = d;
      in_tag   = tg;
      chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      in_data  = '0;
      chk({name, "_early"}, 32'(out_valid), 32'd0);
      step();
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_data"}, out_data, exp);
      chk({name, "_tag"}, 32'(out_tag), 32'(tg));
      step();
      chk({name, "_drain"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic        seen;
      logic [31:0] exp;
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      in_amt      = '0;
      in_op       = '0;
      in_tag      = '0;
      out_ready   = 1'b1;
      c_in_valid  = 1'b0;
      c_in_data   = '0;
      c_in_amt    = '0;
      c_in_op     = '0;
      c_in_tag    = '0;
      c_out_ready = 1'b0;

      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      run1("ror25", OP_ROR, 5'd25, 32'h0000_0080, 4'h5, 32'h0000_4000);
      run1("rol25", OP_ROL, 5'd25, 32'h0000_0080, 4'h6, 32'h0000_0001);
      run1("ror0", OP_ROR, 5'd0, 32'hDEAD_BEEF, 4'h1, 32'hDEAD_BEEF);
      run1("rol0", OP_ROL, 5'd0, 32'hDEAD_BEEF, 4'h2, 32'hDEAD_BEEF);
      run1("shr0", OP_SHR, 5'd0, 32'hDEAD_BEEF, 4'h3, 32'hDEAD_BEEF);
      run1("sra0", OP_SRA, 5'd0, 32'hDEAD_BEEF, 4'h4, 32'hDEAD_BEEF);
      run1("sra4", OP_SRA, 5'd4, 32'h8000_0000, 4'h7, 32'hF800_0000);
      run1("shr31", OP_SHR, 5'd31, 32'h8000_0000, 4'h8, 32'h0000_0001);
      run1("shr4", OP_SHR, 5'd4, 32'h7FFF_FFFF, 4'h9, 32'h07FF_FFFF);
      run1("sra31", OP_SRA, 5'd31, 32'h8000_0000, 4'hA, 32'hFFFF_FFFF);
      run1("sra4p", OP_SRA, 5'd4, 32'h7FFF_FFF0, 4'hB, 32'h07FF_FFFF);
      run1("ror8", OP_ROR, 5'd8, 32'h1234_5678, 4'hC, 32'h7812_3456);
      run1("rol8", OP_ROL, 5'd8, 32'h1234_5678, 4'hD, 32'h3456_7812);
      run1("rol31", OP_ROL, 5'd31, 32'h0000_0001, 4'hE, 32'h8000_0000);

      // Backpressure: two slots fill, third beat waits
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op     = OP_ROR;
      in_amt    = 5'd4;
      in_data   = 32'h10;
      in_tag    = 4'd1;
      chk("bp_acc1", 32'(in_ready), 32'd1);
      step();
      in_data = 32'h20;
      in_tag  = 4'd2;
      chk("bp_acc2", 32'(in_ready), 32'd1);
      step();
      in_data = 32'h30;
      in_tag  = 4'd3;
      chk("bp_full", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_tag1", 32'(out_tag), 32'd1);
      chk("bp_data1", out_data, 32'd1);
      step();
      chk("bp_full_hold", 32'(in_ready), 32'd0);
      chk("bp_tag1_hold", 32'(out_tag), 32'd1);
      chk("bp_data1_hold", out_data, 32'd1);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_valid2", 32'(out_valid), 32'd1);
      chk("bp_tag2", 32'(out_tag), 32'd2);
      chk("bp_data2", out_data, 32'd2);
      step();
      chk("bp_valid3", 32'(out_valid), 32'd1);
      chk("bp_tag3", 32'(out_tag), 32'd3);
      chk("bp_data3", out_data, 32'd3);
      step();
      chk("bp_empty", 32'(out_valid), 32'd0);

      // Reset with two beats in flight
      in_valid = 1'b1;
      in_op    = OP_SHR;
      in_amt   = 5'd0;
      in_data  = 32'hFFFF_0000;
      in_tag   = 4'hA;
      step();
      in_tag = 4'hB;
      step();
      in_valid = 1'b0;
      chk("mid_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_data", out_data, 32'd0);
      chk("mrst_tag", 32'(out_tag), 32'd0);
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         seen = seen | out_valid;
      end
      chk("mrst_ghost", 32'(seen), 32'd0);

      // Fully combinational build
      for (int i = 0; i < 24; i++) begin
         c_in_valid  = 1'($urandom_range(0, 1));
         c_out_ready = 1'($urandom_range(0, 1));
         c_in_op     = 2'($urandom_range(0, 3));
         c_in_amt    = 5'($urandom_range(0, 31));
         c_in_data   = $urandom;
         c_in_tag    = 4'($urandom_range(0, 15));
         #1;
         exp = model(c_in_op, c_in_amt, c_in_data);
         chk("comb_data", c_out_data, exp);
         chk("comb_tag", 32'(c_out_tag), 32'(c_in_tag));
         chk("comb_valid", 32'(c_out_valid), 32'(c_in_valid));
         chk("comb_ready", 32'(c_in_ready), 32'(c_out_ready));
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/rotshift_pipe.md
# rotshift_pipe

- Parametrised pipelined barrel rotator/shifter; successor to the fixed-amount rotate units in the hash datapath.
- Runtime amount and operation: rotate right, rotate left, logical shift right, arithmetic shift right.
- Configurable register placement, valid/ready handshake with per-stage backpressure.
- Sits between operand fetch and the XOR/add combine stage of the compression rounds; also used as a general shifter.

## Interface

Parameters:
- WIDTH, 32, data width; power of two, >= 8.
- SHW, $clog2(WIDTH), amount width; derived, not overridden.
- TAGW, 4, width of the sideband tag carried alongside data.
- REG_MASK, 'b10010, SHW bits; bit k set = register after stage k. LAT = popcount(REG_MASK).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  WIDTH  operand.
- in_amt  in  SHW  shift/rotate amount, 0..WIDTH-1.
- in_op  in  2  rot_op_t: 00 ROR, 01 ROL, 10 SHR, 11 SRA.
- in_tag  in  TAGW  sideband, returned unchanged with result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  WIDTH  result.
- out_tag  out  TAGW  tag of the beat producing out_data.

## Operation

- Stage k (k = 0..SHW-1) shifts by 2^k when effective-amount bit k is set, otherwise passes through.
- ROL is performed as ROR by (WIDTH - amt) mod WIDTH, computed once at input. amt = 0 gives identity for every op.
- ROR/ROL: bits leaving one end re-enter at the other.
- SHR fills vacated MSBs with 0. SRA fills them with the operand MSB captured at input.
- Op, effective amount, sign bit and tag travel with the data through every registered stage.
- Registered stage k holds valid_k and one beat.
  - ready_k = !valid_k || ready_(k+1), where ready after the last stage is out_ready.
  - Bubbles collapse. No global stall.
- Capacity equals LAT beats. Beats leave in acceptance order; no reordering or dropping.

## Timing

- Latency from accept to out_valid = LAT cycles, with no backpressure.
- Throughput: one beat per cycle sustained while out_ready = 1.
- REG_MASK = 0 makes the block fully combinational:
  - out_valid = in_valid
  - in_ready = out_ready
  - out_data is the same-cycle result.
- Reset (rst = 1 at a clk edge):
  - all valid_k = 0, out_valid = 0, out_data = 0, out_tag = 0
  - in_ready = 1 in the cycle after reset when LAT > 0.
- Reset mid-operation discards all in-flight beats. No output for them after reset deasserts.
- Full pipeline with out_ready = 0: in_ready = 0. Registers hold their contents stable.
- When the pipeline is full and out_ready = 1 with in_valid = 1 in the same cycle, every stage advances and the new beat is accepted in that cycle.
- out_data and out_tag are stable while out_valid && !out_ready.

## Structure

- rot_pkg:
  - rot_op_t enum (ROT_ROR, ROT_ROL, ROT_SHR, ROT_SRA).
  - Function popcount_mask used for LAT.
  - Stage payload struct: data, amt, op, sign, tag.
- Sub-module rot_stage, parameters WIDTH, SHW, TAGW, K, REG:
  - one shift-by-2^K mux layer
  - optional output register with valid/ready.
- rotshift_pipe: ROL amount conversion plus a generate loop of rot_stage.

## Test plan

- ROR 25, in_data 0x00000080, LAT = 2, out_ready = 1 -> out_data 0x00004000 exactly 2 cycles after acceptance, tag echoed.
- ROL 25 on 0x00000080 -> 0x00000001. amt = 0 with any op on 0xDEADBEEF -> 0xDEADBEEF.
- SRA 4 on 0x80000000 -> 0xF8000000. SHR 31 on 0x80000000 -> 0x00000001. SHR 4 on 0x7FFFFFFF -> 0x07FFFFFF.
- Backpressure:
  - Hold out_ready = 0 and offer 3 beats, tags 1, 2, 3 -> first 2 accepted, in_ready = 0, outputs held stable.
  - Release -> tags 1, 2, 3 emerge in order, none lost or duplicated.
- Assert rst for one cycle with 2 beats in flight -> out_valid = 0, out_data = 0 after reset, and neither beat ever appears.
- REG_MASK = 0 build -> random ops/amounts match the reference model in the same cycle, and in_ready tracks out_ready combinationally.
